// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(parameter int PC_W = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [12:0]     out_ctrl;
  logic [4:0]      out_shamt;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [15:0]     out_imm16;
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_ctrl, out_shamt, out_rs, out_rt, out_rd, out_imm16
  );
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_ctrl, out_shamt, out_rs, out_rt, out_rd, out_imm16
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: instruction queue with valid/ready on both sides, decoding the head word into control signals.
module decode_stage #(
  parameter int IQ_DEPTH  = 4,
  parameter int PC_W      = 32,
  parameter int LUI_SHAMT = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  decode_stage_if.slave                   bus,
  output logic [$clog2(IQ_DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(IQ_DEPTH);
  localparam int CW = $clog2(IQ_DEPTH + 1);
  localparam logic [3:0] ALUFN_ADD  = 4'd1;
  localparam logic [3:0] ALUFN_SUB  = 4'd2;
  localparam logic [3:0] ALUFN_AND  = 4'd3;
  localparam logic [3:0] ALUFN_OR   = 4'd4;
  localparam logic [3:0] ALUFN_XOR  = 4'd5;
  localparam logic [3:0] ALUFN_NOR  = 4'd6;
  localparam logic [3:0] ALUFN_SLL  = 4'd7;
  localparam logic [3:0] ALUFN_SRL  = 4'd8;
  localparam logic [3:0] ALUFN_SRA  = 4'd9;
  localparam logic [3:0] ALUFN_ROTR = 4'd10;

  logic [PC_W+31:0] mem [IQ_DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             push, pop;
  logic [31:0]      w;
  logic [5:0]       op, fn;
  logic [3:0]       alu_fn;
  logic             legal, ld_st, wsrc, mw, a1, a2, reg_wr;

  assign bus.in_ready  = count < CW'(IQ_DEPTH);
  assign bus.out_valid = count != '0;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end

  // Storage is deliberately left out of reset; outputs are ignored while out_valid=0.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.in_pc, bus.in_instr};

  assign w          = mem[rd_ptr][31:0];
  assign bus.out_pc = mem[rd_ptr][PC_W+31:32];
  assign op         = w[31:26];
  assign fn         = w[5:0];
  assign ld_st      = op[5:4] == 2'b10;
  assign wsrc       = w[31:29] == 3'b100;
  assign mw         = w[31:29] == 3'b101;
  assign a2         = w[31:29] == 3'b001;
  assign a1         = (op == 6'd0 && fn[5:3] == 3'd0) || op == 6'd15;

  always_comb begin
    alu_fn = '0;
    legal  = 1'b1;
    if (op == 6'd0)
      case (fn)
        6'd0, 6'd4:   alu_fn = ALUFN_SLL;
        6'd2, 6'd6:   alu_fn = w[21] ? ALUFN_ROTR : ALUFN_SRL;
        6'd3, 6'd7:   alu_fn = ALUFN_SRA;
        6'd32, 6'd33: alu_fn = ALUFN_ADD;
        6'd34, 6'd35: alu_fn = ALUFN_SUB;
        6'd36:        alu_fn = ALUFN_AND;
        6'd37:        alu_fn = ALUFN_OR;
        6'd38:        alu_fn = ALUFN_XOR;
        6'd39:        alu_fn = ALUFN_NOR;
        default:      legal  = 1'b0;
      endcase
    else
      case (op)
        6'd8, 6'd9: alu_fn = ALUFN_ADD;
        6'd12:      alu_fn = ALUFN_AND;
        6'd13:      alu_fn = ALUFN_OR;
        6'd14:      alu_fn = ALUFN_XOR;
        6'd15:      alu_fn = ALUFN_SLL;
        default: begin
          alu_fn = ld_st ? ALUFN_ADD : 4'd0;
          legal  = ld_st;
        end
      endcase
  end

  assign reg_wr        = legal & (op == 6'd0 | a2 | wsrc);
  assign bus.out_ctrl  = {reg_wr, wsrc, op != 6'd0, a1, a2, legal & mw, w[31:28] != 4'b0011,
                          alu_fn, ~legal, op == 6'd15};
  assign bus.out_shamt = op == 6'd15 ? 5'(LUI_SHAMT) : w[10:6];
  assign bus.out_rs    = w[25:21];
  assign bus.out_rt    = w[20:16];
  assign bus.out_rd    = w[15:11];
  assign bus.out_imm16 = w[15:0];
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus against a queue scoreboard and a rule-level decode model.
module tb_decode_stage;
  localparam int ADD = 1, SUB = 2, AND_ = 3, OR_ = 4, XOR_ = 5, NOR_ = 6, SLL = 7, SRL = 8, SRA = 9, ROTR = 10;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 0;
  logic        reset = 1;
  logic        flush = 0;
  logic [2:0]  count;
  ent_t        q[$];
  bit          pend = 0;
  logic [31:0] pcn = 32'h1000;
  int          tests = 0;
  int          fails = 0;

  decode_stage_if #(.PC_W(32)) bus ();

  decode_stage #(.IQ_DEPTH(4), .PC_W(32), .LUI_SHAMT(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Returns {ctrl[12:0], shamt[4:0]} derived directly from the opcode/funct rules.
  function automatic logic [17:0] model(input logic [31:0] w);
    int op = int'(w[31:26]);
    int fn = int'(w[5:0]);
    int alu = 0;
    bit ok = 1, regwr = 0, a1 = 0, lui = 0;
    bit se = w[31:28] != 4'd3;
    bit dst = op != 0;
    bit wsrc = op >= 32 && op < 40;
    bit mw = op >= 40 && op < 48;
    bit a2 = op >= 8 && op < 16;
    logic [3:0] alu4;
    if (op == 0) begin
      regwr = 1;
      a1 = fn < 8;
      if (fn < 8 && fn != 1 && fn != 5)
        alu = (fn % 4 == 0) ? SLL : (fn % 4 == 2) ? (w[21] ? ROTR : SRL) : SRA;
      else if (fn >= 32 && fn <= 39)
        alu = fn < 34 ? ADD : fn < 36 ? SUB : fn == 36 ? AND_ : fn == 37 ? OR_ : fn == 38 ? XOR_ : NOR_;
      else
        ok = 0;
    end else if (a2) begin
      regwr = 1;
      if (op == 8 || op == 9) alu = ADD;
      else if (op == 12) alu = AND_;
      else if (op == 13) alu = OR_;
      else if (op == 14) alu = XOR_;
      else if (op == 15) begin alu = SLL; a1 = 1; lui = 1; end
      else ok = 0;
    end else if (op >= 32 && op < 48) begin
      alu = ADD;
      regwr = wsrc;
    end else
      ok = 0;
    if (!ok) begin regwr = 0; mw = 0; alu = 0; end
    alu4 = 4'(alu);
    return {regwr, wsrc, dst, a1, a2, mw, se, alu4, !ok, lui, (op == 15) ? 5'd16 : w[10:6]};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 3))
      0: w[31:26] = 6'd0;
      1: w[31:26] = 6'($urandom_range(8, 15));
      2: w[31:26] = 6'($urandom_range(32, 47));
      default: ;
    endcase
    if (w[31:26] == 6'd0 && $urandom_range(0, 1) == 1)
      w[5:0] = 6'($urandom_range(0, 1) * 32 + $urandom_range(0, 7));
    return w;
  endfunction

  task automatic cyc(input logic v, input logic [31:0] w, input logic r, input logic f);
    @(negedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.in_pc     = pcn;
    bus.out_ready = r;
    flush         = f;
    pend = v && bus.in_ready && !f;
    if (pend) q.push_back('{pcn, w});
    pcn += 4;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && count != 0; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("drain_count", 32'(count), 0);
  endtask

  // Monitor: compares every presented head against the scoreboard just before the active edge.
  initial begin
    forever begin
      int exp_cnt;
      logic [17:0] m;
      @(negedge clk);
      #3;
      if (!reset) begin
        exp_cnt = q.size() - int'(pend);
        chk("count", 32'(count), 32'(exp_cnt));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_cnt != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_cnt < 4));
        if (exp_cnt > 0 && bus.out_ready) begin
          m = model(q[0].instr);
          chk("out_pc", bus.out_pc, q[0].pc);
          chk("out_ctrl", 32'(bus.out_ctrl), 32'(m[17:5]));
          chk("out_shamt", 32'(bus.out_shamt), 32'(m[4:0]));
          chk("out_rs", 32'(bus.out_rs), q[0].instr >> 21 & 32'h1f);
          chk("out_rt", 32'(bus.out_rt), q[0].instr >> 16 & 32'h1f);
          chk("out_rd", 32'(bus.out_rd), q[0].instr >> 11 & 32'h1f);
          chk("out_imm16", 32'(bus.out_imm16), q[0].instr & 32'hffff);
        end
        if (flush) q.delete();
        else if (exp_cnt > 0 && bus.out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.out_ready = 0;
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    reset = 0;

    // add $2,$4,$5 into an empty queue
    cyc(1, 32'h00851020, 0, 0);
    chk("add_no_bypass", 32'(bus.out_valid), 0);
    cyc(0, 0, 0, 0);
    chk("add_valid", 32'(bus.out_valid), 1);
    chk("add_ctrl", 32'(bus.out_ctrl), 32'h1044);
    chk("add_rs", 32'(bus.out_rs), 4);
    chk("add_rt", 32'(bus.out_rt), 5);
    chk("add_rd", 32'(bus.out_rd), 2);
    drain();

    // fill to full across pointer wrap, then 5th word after a pop
    for (int i = 0; i < 4; i++) cyc(1, rnd_instr(), 0, 0);
    cyc(1, 32'h2008_0005, 0, 0);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    cyc(1, 32'h2008_0005, 1, 0);
    chk("full_hold", 32'(count), 4);
    chk("full_ready_during_pop", 32'(bus.in_ready), 0);
    cyc(1, 32'h2008_0005, 1, 0);
    chk("after_pop_count", 32'(count), 3);
    drain();

    // lui
    cyc(1, 32'h3C011234, 0, 0);
    cyc(0, 0, 0, 0);
    chk("lui_ctrl", 32'(bus.out_ctrl), 32'h171D);
    chk("lui_shamt", 32'(bus.out_shamt), 16);
    chk("lui_imm16", 32'(bus.out_imm16), 32'h1234);
    drain();

    // illegal opcode and illegal funct, both popped normally
    cyc(1, 32'hFC000000, 0, 0);
    cyc(1, 32'h0000003F, 0, 0);
    cyc(0, 0, 1, 0);
    chk("ill_op_ctrl", 32'(bus.out_ctrl), 32'h0442);
    cyc(0, 0, 1, 0);
    chk("ill_fn_ctrl", 32'(bus.out_ctrl), 32'h0042);
    cyc(0, 0, 0, 0);
    chk("ill_popped", 32'(count), 0);

    // flush overrides push and pop
    cyc(1, 32'h012A4022, 0, 0);
    cyc(1, 32'h8D280004, 0, 0);
    cyc(1, 32'hAD280008, 1, 1);
    chk("pre_flush_count", 32'(count), 2);
    cyc(0, 0, 0, 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_out_valid", 32'(bus.out_valid), 0);

    // asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) cyc(1, rnd_instr(), 0, 0);
    cyc(0, 0, 0, 0);
    chk("pre_reset_count", 32'(count), 3);
    #1;
    reset = 1;
    q.delete();
    pend = 0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_out_valid", 32'(bus.out_valid), 0);
    chk("async_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    reset = 0;

    // random traffic
    for (int i = 0; i < 2000; i++)
      cyc(logic'($urandom_range(0, 9) < 6), rnd_instr(), logic'($urandom_range(0, 9) < 6),
          logic'($urandom_range(0, 39) == 0));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
